// File: rtl/dilithium_stream_pkg.sv
// Shared types and header-length table for the Dilithium stream adapters.
package dilithium_stream_pkg;

  typedef enum logic [1:0] {
    MODE_KEYGEN = 2'd0,
    MODE_VERIFY = 2'd1,
    MODE_SIGN   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_MSG,
    ST_FLUSH
  } ingress_state_e;

  localparam logic [9:0] HDR_KEYGEN    = 10'd4;
  localparam logic [9:0] HDR_VERIFY_L2 = 10'd467;
  localparam logic [9:0] HDR_VERIFY_L3 = 10'd656;
  localparam logic [9:0] HDR_VERIFY_L5 = 10'd899;
  localparam logic [9:0] HDR_SIGN_L2   = 10'd316;
  localparam logic [9:0] HDR_SIGN_L3   = 10'd500;
  localparam logic [9:0] HDR_SIGN_L5   = 10'd608;

  // Unknown security levels fall back to level 5; reserved mode sizes like keygen.
  function automatic logic [9:0] hdr_words(input mode_e mode, input logic [2:0] sec_lvl);
    logic [9:0] n;
    n = HDR_KEYGEN;
    case (mode)
      MODE_VERIFY: begin
        case (sec_lvl)
          3'd2:    n = HDR_VERIFY_L2;
          3'd3:    n = HDR_VERIFY_L3;
          default: n = HDR_VERIFY_L5;
        endcase
      end
      MODE_SIGN: begin
        case (sec_lvl)
          3'd2:    n = HDR_SIGN_L2;
          3'd3:    n = HDR_SIGN_L3;
          default: n = HDR_SIGN_L5;
        endcase
      end
      default: n = HDR_KEYGEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with synchronous flush; any depth >= 2, show-ahead read data.
module fifo_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stream_ingress_adapter.sv
// Frames an external valid/ready/last word stream into the Dilithium core input port.
// Optional framing checks on protocol_err are enabled by defining INGRESS_PROTOCOL_CHECK_EN.
module stream_ingress_adapter
  import dilithium_stream_pkg::*;
#(
  parameter int w          = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [2:0]   sec_lvl,
  input  logic         valid_i,
  output logic         ready_i,
  input  logic [w-1:0] data_i,
  input  logic         last_i,
  output logic         dilithium_valid_i,
  input  logic         dilithium_ready_i,
  output logic [w-1:0] dilithium_data_i,
  output logic         busy,
  output logic         done,
  output logic         protocol_err
);

`ifdef INGRESS_PROTOCOL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  ingress_state_e state_q, state_d;
  mode_e          mode_q;
  logic [9:0]     cnt_q;
  logic           fifo_full, fifo_empty;
  logic           accept, hdr_accept, hdr_final, keygen_like, start_to_flush;

  assign ready_i     = ((state_q == ST_HDR) || (state_q == ST_MSG)) && !fifo_full;
  assign accept      = valid_i && ready_i;
  assign hdr_accept  = accept && (state_q == ST_HDR);
  assign hdr_final   = (cnt_q == 10'd1);
  // Reserved mode only reaches HDR when checking is off, and is then framed as keygen.
  assign keygen_like = (mode_q == MODE_KEYGEN) || (mode_q == MODE_RSVD);
  assign start_to_flush = CHECK_EN && (mode_e'(mode) == MODE_RSVD);
  assign busy        = (state_q != ST_IDLE);

  fifo_buffer #(
    .WIDTH (w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .push      (accept),
    .push_data (data_i),
    .pop       (dilithium_ready_i),
    .pop_data  (dilithium_data_i),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dilithium_valid_i = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_KEYGEN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mode_q <= mode_e'(mode);
        cnt_q  <= hdr_words(mode_e'(mode), sec_lvl);
      end else if (hdr_accept) begin
        cnt_q <= cnt_q - 10'd1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_HDR:   if (hdr_accept && hdr_final) state_d = keygen_like ? ST_FLUSH : ST_MSG;
      ST_MSG:   if (accept && last_i) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    // start aborts any frame in flight and never produces done for it.
    if (start) begin
      state_d = start_to_flush ? ST_FLUSH : ST_HDR;
      done    = 1'b0;
    end
    if (rst) done = 1'b0;
  end

`ifdef INGRESS_PROTOCOL_CHECK_EN
  logic perr_q;

  // last_i must be high on keygen's final header word and low on every other header word.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (start) begin
      perr_q <= (mode_e'(mode) == MODE_RSVD);
    end else if (hdr_accept && (last_i != (keygen_like && hdr_final))) begin
      perr_q <= 1'b1;
    end
  end

  assign protocol_err = perr_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule
